bist_cb_session_ctrl: RTL and testbench
=======================================

Name: bist_cb_session_ctrl

Overview:
- Upstream sequencer for the checkerboard BIST wrapper of the 16x2 SRAM.
- Drives the wrapper's `tester` select and runs NUM_RUNS back-to-back checkerboard passes.
- Consumes the wrapper's `test_down` and `pass_or_fail` per pass and reports an aggregate verdict, fail count and timeout status to the system.
- While idle or done it holds `tester` low, so the SRAM stays on normal-mode inputs.

Parameters:
- NUM_RUNS, 4, number of BIST passes per session (1..255).
- TIMEOUT_CYC, 256, max cycles in RUN waiting for test_down before the pass is declared failed.
- GAP_CYC, 2, cycles tester is held low between passes to re-arm the BIST engine (>=1).
- CNT_W, 8, width of run/fail counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a session from IDLE or DONE.
- abort  in  1  level; terminates the session.
- test_down  in  1  BIST pass-complete from the wrapper.
- pass_or_fail  in  1  BIST verdict from the wrapper; 1 = pass; valid when test_down=1.
- tester  out  1  wrapper mux select; 1 = BIST owns the SRAM.
- busy  out  1  session in progress.
- done  out  1  session finished; held until next start.
- result_pass  out  1  1 = all passes passed and no timeout; valid when done=1.
- run_count  out  CNT_W  passes completed this session.
- fail_count  out  CNT_W  passes failed (including timeouts) this session.
- timeout_err  out  1  sticky; set if any pass timed out.

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE.
  - tester=0, busy=0, done=0, result_pass=0, run_count=0, fail_count=0, timeout_err=0.
  - A reset mid-session drops tester the next cycle.
- States: IDLE, RUN, GAP, DONE. All outputs are registered.
- IDLE or DONE, start=1:
  - Next state RUN; tester=1, busy=1, done=0.
  - run_count, fail_count, timeout_err and the cycle timer are cleared.
  - start in any other state is ignored.
- RUN: the timer increments each cycle.
  - test_down=1: run_count+1; fail_count+1 if pass_or_fail=0; tester=0 next cycle; go to GAP.
  - Else, timer reaches TIMEOUT_CYC-1: run_count+1, fail_count+1, timeout_err=1, tester=0, go to GAP.
  - test_down and timer expiry in the same cycle: test_down wins and the timeout is not flagged.
- GAP:
  - Holds tester=0 for exactly GAP_CYC cycles.
  - If run_count==NUM_RUNS, go to DONE.
  - Otherwise reload the timer to 0 and return to RUN with tester=1.
  - test_down/pass_or_fail are ignored in GAP.
- DONE:
  - busy=0, done=1, tester=0.
  - result_pass=(fail_count==0 and timeout_err==0).
  - Counters hold.
- abort=1 in RUN or GAP:
  - Next cycle: state DONE, tester=0, result_pass=0, counters frozen at current values.
  - abort in IDLE/DONE has no effect.
  - abort has priority over start and test_down in the same cycle.
- Counters saturate at 2^CNT_W-1; no wrap.
- Latency:
  - start to tester=1: 1 cycle.
  - test_down to tester=0: 1 cycle.
  - Final test_down to done=1: GAP_CYC+1 cycles.

Optional Feature:
- Macro: BIST_CB_FAIL_STOP_EN.
- Defined: the first failing or timed-out pass ends the session. After its GAP the block goes to DONE with result_pass=0, regardless of run_count.
- Undefined: all NUM_RUNS passes always execute.

Test Plan:
- Reset: rst=1 for 2 cycles mid-RUN -> cycle after, tester=0, busy=0, done=0, counters=0.
- Nominal (NUM_RUNS=4): start, then 4 test_down pulses each with pass_or_fail=1 -> run_count=4, fail_count=0, done=1 exactly GAP_CYC+1 cycles after the 4th pulse, result_pass=1, tester low for exactly 2 cycles between passes.
- Mixed: passes 2 and 4 report pass_or_fail=0 -> fail_count=2, result_pass=0, timeout_err=0.
- Timeout (TIMEOUT_CYC=16): no test_down in pass 3 -> tester drops after 16 RUN cycles, timeout_err=1, fail_count=1, session still completes with run_count=4.
- Abort: abort=1 asserted together with test_down during pass 2 -> DONE next cycle, run_count=1, result_pass=0; a later start restarts with cleared counters.
- Feature on (BIST_CB_FAIL_STOP_EN): pass 1 fails -> done after GAP with run_count=1, fail_count=1, result_pass=0; feature off -> same stimulus yields run_count=4.

Source files
------------

// File: rtl/bist_cb_session_ctrl.sv
// Session sequencer for the checkerboard BIST wrapper: runs NUM_RUNS passes and reports an aggregate verdict.
// Optional: define BIST_CB_FAIL_STOP_EN to end the session after the first failing or timed-out pass.
module bist_cb_session_ctrl #(
  parameter int NUM_RUNS    = 4,
  parameter int TIMEOUT_CYC = 256,
  parameter int GAP_CYC     = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             test_down,
  input  logic             pass_or_fail,
  output logic             tester,
  output logic             busy,
  output logic             done,
  output logic             result_pass,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] RUNS     = CNT_W'(NUM_RUNS);

`ifdef BIST_CB_FAIL_STOP_EN
  localparam bit FAIL_STOP = 1'b1;
`else
  localparam bit FAIL_STOP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t           state_reg;
  logic [TMR_W-1:0] timer_reg;
  logic [GAP_W-1:0] gap_reg;
  logic             end_session;

  // A session that has seen any failure can only be stopped early when fail-stop is built in.
  assign end_session = (run_count >= RUNS) || (FAIL_STOP && (fail_count != '0));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      gap_reg     <= '0;
      tester      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_pass <= 1'b0;
      run_count   <= '0;
      fail_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg   <= RUN;
            tester      <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            result_pass <= 1'b0;
            run_count   <= '0;
            fail_count  <= '0;
            timeout_err <= 1'b0;
            timer_reg   <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state_reg   <= DONE;
            tester      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            result_pass <= 1'b0;
          end else if (test_down) begin
            // A completion on the last timer cycle still counts as a normal completion.
            run_count <= sat_inc(run_count);
            if (!pass_or_fail) fail_count <= sat_inc(fail_count);
            tester    <= 1'b0;
            gap_reg   <= '0;
            state_reg <= GAP;
          end else if (timer_reg == TMR_LAST) begin
            run_count   <= sat_inc(run_count);
            fail_count  <= sat_inc(fail_count);
            timeout_err <= 1'b1;
            tester      <= 1'b0;
            gap_reg     <= '0;
            state_reg   <= GAP;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        GAP: begin
          if (abort) begin
            state_reg   <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            result_pass <= 1'b0;
          end else if (gap_reg == GAP_LAST) begin
            if (end_session) begin
              state_reg   <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              result_pass <= (fail_count == '0) && !timeout_err;
            end else begin
              state_reg <= RUN;
              tester    <= 1'b1;
              timer_reg <= '0;
            end
          end else begin
            gap_reg <= gap_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_cb_session_ctrl.sv
// Bench for bist_cb_session_ctrl: a stand-in BIST engine answers each pass after a random delay,
// and a pass-level outcome model predicts tester shape, counters and verdict.
module tb_bist_cb_session_ctrl;

  localparam int NR  = 4;
  localparam int TO  = 16;
  localparam int GAP = 2;
  localparam int W   = 8;

`ifdef BIST_CB_FAIL_STOP_EN
  localparam bit FS = 1'b1;
`else
  localparam bit FS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, abort, test_down, pass_or_fail;
  logic         tester, busy, done, result_pass, timeout_err;
  logic [W-1:0] run_count, fail_count;

  int checks   = 0;
  int failures = 0;
  int dly[NR];   // high cycle in which test_down is returned; > TO means never (timeout)
  bit vrd[NR];

  bist_cb_session_ctrl #(.NUM_RUNS(NR), .TIMEOUT_CYC(TO), .GAP_CYC(GAP), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .test_down(test_down),
    .pass_or_fail(pass_or_fail), .tester(tester), .busy(busy), .done(done),
    .result_pass(result_pass), .run_count(run_count), .fail_count(fail_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic run_session(input string name, input int abort_pass);
    int len, n_loop, e_run, e_fail;
    bit e_to, aborted, e_res, failed;
    e_run = 0; e_fail = 0; e_to = 0; aborted = 0;
    for (int p = 0; p < NR; p++) begin
      if (abort_pass == p + 1) begin aborted = 1; break; end
      failed = (dly[p] > TO) || !vrd[p];
      e_run++;
      if (failed) e_fail++;
      if (dly[p] > TO) e_to = 1;
      if (FS && failed) break;
    end
    n_loop = aborted ? abort_pass : e_run;
    e_res  = !aborted && (e_fail == 0) && !e_to;

    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    checks++;
    if (run_count !== 0 || fail_count !== 0 || timeout_err !== 0 || done !== 0 || busy !== 1) begin
      failures++;
      $display("FAIL %s start_clear: run=%0d fail=%0d to=%0b done=%0b busy=%0b, need 0 0 0 0 1",
               name, run_count, fail_count, timeout_err, done, busy);
    end

    for (int p = 0; p < n_loop; p++) begin
      len = (dly[p] > TO) ? TO : dly[p];
      for (int k = 1; k <= len; k++) begin
        checks++;
        if (tester !== 1'b1) begin
          failures++;
          $display("FAIL %s tester_high pass%0d cyc%0d: tester=%b, need 1", name, p + 1, k, tester);
        end
        if (k < len) start = 1'($urandom_range(0, 1));
        if (k == len && dly[p] <= TO) begin
          test_down    = 1;
          pass_or_fail = vrd[p];
          abort        = (p == abort_pass - 1);
        end
        @(negedge clk);
        test_down = 0; abort = 0; start = 0; pass_or_fail = 1'($urandom);
      end
      if (aborted && p == abort_pass - 1) begin
        checks++;
        if (done !== 1 || tester !== 0 || busy !== 0 || result_pass !== 0) begin
          failures++;
          $display("FAIL %s abort_state: done=%b tester=%b busy=%b res=%b, need 1 0 0 0",
                   name, done, tester, busy, result_pass);
        end
        break;
      end
      for (int g = 1; g <= GAP; g++) begin
        checks++;
        if (tester !== 0 || busy !== 1 || done !== 0) begin
          failures++;
          $display("FAIL %s gap pass%0d cyc%0d: tester=%b busy=%b done=%b, need 0 1 0",
                   name, p + 1, g, tester, busy, done);
        end
        test_down    = 1'($urandom);
        pass_or_fail = 1'($urandom);
        @(negedge clk);
        test_down = 0;
      end
    end

    if (!aborted) begin
      checks++;
      if (done !== 1 || busy !== 0 || tester !== 0) begin
        failures++;
        $display("FAIL %s done_timing: done=%b busy=%b tester=%b, need 1 0 0", name, done, busy, tester);
      end
      checks++;
      if (result_pass !== e_res) begin
        failures++;
        $display("FAIL %s result_pass: got %b, need %b", name, result_pass, e_res);
      end
    end
    checks++;
    if (run_count !== W'(e_run) || fail_count !== W'(e_fail) || timeout_err !== e_to) begin
      failures++;
      $display("FAIL %s counters: run=%0d fail=%0d to=%b, need run=%0d fail=%0d to=%b",
               name, run_count, fail_count, timeout_err, e_run, e_fail, e_to);
    end
    $display("session %s: dly=%0d/%0d/%0d/%0d vrd=%b%b%b%b abort=%0d -> run=%0d fail=%0d to=%b res=%b",
             name, dly[0], dly[1], dly[2], dly[3], vrd[0], vrd[1], vrd[2], vrd[3], abort_pass,
             run_count, fail_count, timeout_err, result_pass);
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1 || run_count !== W'(e_run) || fail_count !== W'(e_fail)) begin
      failures++;
      $display("FAIL %s done_hold: done=%b run=%0d fail=%0d", name, done, run_count, fail_count);
    end
  endtask

  task automatic set_all_pass();
    for (int p = 0; p < NR; p++) begin
      dly[p] = $urandom_range(1, 12);
      vrd[p] = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; abort = 0; test_down = 0; pass_or_fail = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (tester !== 0 || busy !== 0 || done !== 0 || result_pass !== 0 ||
        run_count !== 0 || fail_count !== 0 || timeout_err !== 0) begin
      failures++;
      $display("FAIL reset_init: tester=%b busy=%b done=%b res=%b run=%0d fail=%0d to=%b, need all 0",
               tester, busy, done, result_pass, run_count, fail_count, timeout_err);
    end
    rst = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (tester !== 1) begin
      failures++;
      $display("FAIL reset_pre_run: tester=%b, need 1", tester);
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if (tester !== 0) begin
      failures++;
      $display("FAIL reset_tester_drop: tester=%b, need 0", tester);
    end
    @(negedge clk); rst = 0;
    checks++;
    if (tester !== 0 || busy !== 0 || done !== 0 || run_count !== 0 || fail_count !== 0 || timeout_err !== 0) begin
      failures++;
      $display("FAIL reset_mid_run: tester=%b busy=%b done=%b run=%0d fail=%0d to=%b, need all 0",
               tester, busy, done, run_count, fail_count, timeout_err);
    end
    $display("reset: mid-run reset applied, tester=%b busy=%b", tester, busy);
  endtask

  task automatic test_nominal();
    set_all_pass();
    run_session("nominal", 0);
  endtask

  task automatic test_mixed();
    set_all_pass();
    vrd[1] = 0; vrd[3] = 0;
    run_session("mixed", 0);
  endtask

  task automatic test_timeout();
    set_all_pass();
    dly[2] = 99;
    run_session("timeout", 0);
  endtask

  task automatic test_boundary();
    set_all_pass();
    dly[0] = TO; dly[1] = 1; dly[2] = TO - 1; dly[3] = TO;
    run_session("boundary", 0);
  endtask

  task automatic test_abort();
    set_all_pass();
    run_session("abort", 2);
    abort = 1;
    repeat (2) @(negedge clk);
    abort = 0;
    checks++;
    if (done !== 1 || tester !== 0 || result_pass !== 0 || run_count !== 1) begin
      failures++;
      $display("FAIL abort_in_done: done=%b tester=%b res=%b run=%0d, need 1 0 0 1",
               done, tester, result_pass, run_count);
    end
    set_all_pass();
    run_session("restart", 0);
  endtask

  task automatic test_fail_stop();
    set_all_pass();
    vrd[0] = 0;
    run_session("fail_stop", 0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      for (int p = 0; p < NR; p++) begin
        dly[p] = $urandom_range(1, 20);
        vrd[p] = ($urandom_range(0, 3) != 0);
      end
      run_session("random", 0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mixed();
    test_timeout();
    test_boundary();
    test_abort();
    test_fail_stop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
